// File: rtl/pad_input_conditioner.sv
// Pad input conditioner: per-pad synchroniser, glitch filter, edge detect and sticky event status.
// Optional glitch counter enabled by defining PAD_IN_COND_GLITCH_CNT_EN.
module pad_input_conditioner #(
    parameter int                    NUM_PADS    = 8,
    parameter int                    SYNC_STAGES = 2,
    parameter int                    FILT_CNT_W  = 8,
    parameter logic [NUM_PADS-1:0]   RESET_VAL   = '0
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [NUM_PADS-1:0]   pad_in_i,
    input  logic [NUM_PADS-1:0]   filt_en_i,
    input  logic [FILT_CNT_W-1:0] filt_len_i,
    input  logic [NUM_PADS-1:0]   rise_en_i,
    input  logic [NUM_PADS-1:0]   fall_en_i,
    input  logic [NUM_PADS-1:0]   irq_mask_i,
    input  logic [NUM_PADS-1:0]   evt_clr_i,
    output logic [NUM_PADS-1:0]   in_o,
    output logic [NUM_PADS-1:0]   rise_o,
    output logic [NUM_PADS-1:0]   fall_o,
    output logic [NUM_PADS-1:0]   evt_status_o,
    output logic                  irq_o,
    output logic [15:0]           glitch_cnt_o,
    input  logic                  glitch_cnt_clr_i
);

    localparam logic [FILT_CNT_W-1:0] CNT_MAX = '1;
    localparam logic [FILT_CNT_W-1:0] CNT_ONE = {{(FILT_CNT_W-1){1'b0}}, 1'b1};

    // True once one more cycle of disagreement reaches the required filter length.
    function automatic logic len_reached(input logic [FILT_CNT_W-1:0] cnt,
                                         input logic [FILT_CNT_W-1:0] len);
        logic [FILT_CNT_W:0] inc;
        inc = {1'b0, cnt} + {{FILT_CNT_W{1'b0}}, 1'b1};
        return (inc >= {1'b0, len});
    endfunction

    logic [NUM_PADS-1:0]   sync_r [SYNC_STAGES];
    logic [NUM_PADS-1:0]   s_s;
    logic [NUM_PADS-1:0]   filt_r;
    logic [NUM_PADS-1:0]   prev_r;
    logic [NUM_PADS-1:0]   status_r;
    logic [NUM_PADS-1:0]   filt_nxt_s;
    logic [NUM_PADS-1:0]   glitch_s;
    logic [NUM_PADS-1:0]   set_s;
    logic [FILT_CNT_W-1:0] cnt_r     [NUM_PADS];
    logic [FILT_CNT_W-1:0] cnt_nxt_s [NUM_PADS];
    logic [FILT_CNT_W-1:0] len_s;

    assign s_s   = sync_r[SYNC_STAGES-1];
    assign len_s = (filt_len_i == {FILT_CNT_W{1'b0}}) ? CNT_ONE : filt_len_i;

    // Synchroniser chain bringing the asynchronous pad levels into clk_i.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_r[i] <= RESET_VAL;
            end
        end else begin
            sync_r[0] <= pad_in_i;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_r[i] <= sync_r[i-1];
            end
        end
    end

    // Next filtered level and counter per pad; a nonzero count that collapses is a rejected glitch.
    always_comb begin
        filt_nxt_s = filt_r;
        glitch_s   = '0;
        for (int k = 0; k < NUM_PADS; k++) begin
            cnt_nxt_s[k] = '0;
            if (!filt_en_i[k]) begin
                filt_nxt_s[k] = s_s[k];
                cnt_nxt_s[k]  = '0;
            end else if (s_s[k] != filt_r[k]) begin
                if (len_reached(cnt_r[k], len_s)) begin
                    filt_nxt_s[k] = s_s[k];
                    cnt_nxt_s[k]  = '0;
                end else if (cnt_r[k] == CNT_MAX) begin
                    cnt_nxt_s[k]  = cnt_r[k];
                end else begin
                    cnt_nxt_s[k]  = cnt_r[k] + CNT_ONE;
                end
            end else begin
                glitch_s[k]  = (cnt_r[k] != {FILT_CNT_W{1'b0}});
                cnt_nxt_s[k] = '0;
            end
        end
    end

    // Filter state and previous level used for edge detection.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            filt_r <= RESET_VAL;
            prev_r <= RESET_VAL;
            for (int k = 0; k < NUM_PADS; k++) begin
                cnt_r[k] <= '0;
            end
        end else begin
            filt_r <= filt_nxt_s;
            prev_r <= filt_r;
            for (int k = 0; k < NUM_PADS; k++) begin
                cnt_r[k] <= cnt_nxt_s[k];
            end
        end
    end

    assign rise_o = filt_r & ~prev_r;
    assign fall_o = ~filt_r & prev_r;
    assign set_s  = (rise_o & rise_en_i) | (fall_o & fall_en_i);

    // Sticky event flags; a new event wins over a clear strobe in the same cycle.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            status_r <= '0;
        end else begin
            status_r <= set_s | (status_r & ~evt_clr_i);
        end
    end

    assign in_o         = filt_r;
    assign evt_status_o = status_r;
    assign irq_o        = |(status_r & irq_mask_i);

`ifdef PAD_IN_COND_GLITCH_CNT_EN
    logic [15:0] gcnt_r;

    // Saturating count of cycles in which any pad rejected a glitch.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            gcnt_r <= 16'h0000;
        end else if (glitch_cnt_clr_i) begin
            gcnt_r <= 16'h0000;
        end else if ((|glitch_s) && (gcnt_r != 16'hFFFF)) begin
            gcnt_r <= gcnt_r + 16'h0001;
        end else begin
            gcnt_r <= gcnt_r;
        end
    end

    assign glitch_cnt_o = gcnt_r;
`else
    logic unused_s;

    assign unused_s     = glitch_cnt_clr_i | (|glitch_s);
    assign glitch_cnt_o = 16'h0000;
`endif

endmodule

// File: tb/tb_pad_input_conditioner.sv
// Self-checking bench for pad_input_conditioner: directed scenarios plus randomized stimulus
// compared every cycle against a rule-level reference model.
module tb_pad_input_conditioner;

    localparam int N  = 8;
    localparam int SS = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  pad, filt_en, filt_len, rise_en, fall_en, mask, clr;
    logic        gclr;
    logic [7:0]  in_v, rise_v, fall_v, stat_v;
    logic        irq_v;
    logic [15:0] gcnt_v;

    pad_input_conditioner dut (
        .clk_i(clk), .rst_i(rst), .pad_in_i(pad), .filt_en_i(filt_en), .filt_len_i(filt_len),
        .rise_en_i(rise_en), .fall_en_i(fall_en), .irq_mask_i(mask), .evt_clr_i(clr),
        .in_o(in_v), .rise_o(rise_v), .fall_o(fall_v), .evt_status_o(stat_v), .irq_o(irq_v),
        .glitch_cnt_o(gcnt_v), .glitch_cnt_clr_i(gclr)
    );

    always #5 clk = ~clk;

    int vec_cnt = 0;
    int err_cnt = 0;

    // Reference model: sampled pad history, accepted level, disagreement run length per pad.
    logic [7:0] m_hist [SS];
    logic [7:0] m_filt, m_prev, m_stat;
    int         m_run [N];
    int         m_gcnt;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < SS; i++) m_hist[i] = 8'h00;
        m_filt = 8'h00; m_prev = 8'h00; m_stat = 8'h00; m_gcnt = 0;
        for (int k = 0; k < N; k++) m_run[k] = 0;
    endtask

    task automatic model_step();
        logic [7:0] s, ev;
        bit         g;
        int         len;
        s   = m_hist[SS-1];
        ev  = ((m_filt & ~m_prev) & rise_en) | ((~m_filt & m_prev) & fall_en);
        m_stat = ev | (m_stat & ~clr);
        m_prev = m_filt;
        len = (filt_len == 8'd0) ? 1 : int'(filt_len);
        g   = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (!filt_en[k]) begin
                m_filt[k] = s[k]; m_run[k] = 0;
            end else if (s[k] != m_filt[k]) begin
                if (m_run[k] + 1 >= len) begin m_filt[k] = s[k]; m_run[k] = 0; end
                else m_run[k] = m_run[k] + 1;
            end else begin
                if (m_run[k] != 0) g = 1'b1;
                m_run[k] = 0;
            end
        end
        if (gclr) m_gcnt = 0;
        else if (g && m_gcnt < 65535) m_gcnt = m_gcnt + 1;
        for (int i = SS - 1; i > 0; i--) m_hist[i] = m_hist[i-1];
        m_hist[0] = pad;
    endtask

    task automatic compare_all();
        check_eq("in_o", {24'h0, in_v}, {24'h0, m_filt});
        check_eq("rise_o", {24'h0, rise_v}, {24'h0, m_filt & ~m_prev});
        check_eq("fall_o", {24'h0, fall_v}, {24'h0, ~m_filt & m_prev});
        check_eq("evt_status_o", {24'h0, stat_v}, {24'h0, m_stat});
        check_eq("irq_o", {31'h0, irq_v}, {31'h0, |(m_stat & mask)});
`ifdef PAD_IN_COND_GLITCH_CNT_EN
        check_eq("glitch_cnt_o", {16'h0, gcnt_v}, m_gcnt);
`else
        check_eq("glitch_cnt_o", {16'h0, gcnt_v}, 32'h0);
`endif
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst) model_reset();
        else model_step();
        @(negedge clk);
        compare_all();
    endtask

    int rises, falls, highs, waited;

    initial begin
        rst = 1'b1; pad = 8'hFF; filt_en = 8'h00; filt_len = 8'd4; rise_en = 8'hFF;
        fall_en = 8'h00; mask = 8'h00; clr = 8'h00; gclr = 1'b0;
        #1 model_reset();
        // Reset state while the pads are already high.
        tick(); tick();
        check_eq("rst_in", {24'h0, in_v}, 32'h0);
        check_eq("rst_status", {24'h0, stat_v}, 32'h0);
        rst = 1'b0;
        rises = 0;
        for (int c = 0; c < 8; c++) begin
            tick();
            if (rise_v == 8'hFF) rises++;
        end
        check_eq("t1_in", {24'h0, in_v}, 32'hFF);
        check_eq("t1_rise_cnt", rises, 32'd1);
        check_eq("t1_status", {24'h0, stat_v}, 32'hFF);

        // Short pulse on pad 0 shorter than the filter length.
        rst = 1'b1; pad = 8'h00; tick(); rst = 1'b0;
        for (int c = 0; c < 4; c++) tick();
        filt_en = 8'hFF; filt_len = 8'd4; rise_en = 8'h00;
        pad = 8'h01;
        rises = 0;
        for (int c = 0; c < 3; c++) begin tick(); if (rise_v[0]) rises++; end
        pad = 8'h00;
        for (int c = 0; c < 10; c++) begin tick(); if (rise_v[0]) rises++; end
        check_eq("t2_rise_cnt", rises, 32'd0);
        check_eq("t2_in", {24'h0, in_v}, 32'h0);
`ifdef PAD_IN_COND_GLITCH_CNT_EN
        check_eq("t2_glitch", {16'h0, gcnt_v}, 32'd1);
`else
        check_eq("t2_glitch", {16'h0, gcnt_v}, 32'd0);
`endif

        // Step on pad 0 held through the filter period.
        pad = 8'h01; rises = 0; waited = 0;
        while (in_v[0] !== 1'b1 && waited < 20) begin
            tick(); waited++;
            if (rise_v[0]) rises++;
        end
        check_eq("t3_timeout", {31'h0, waited >= 20}, 32'd0);
        for (int c = 0; c < 6; c++) begin tick(); if (rise_v[0]) rises++; end
        check_eq("t3_rise_cnt", rises, 32'd1);

        // One-cycle pulse on pad 3 in bypass.
        filt_en = 8'h00; pad = 8'h01; tick(); tick(); tick();
        pad = 8'h09; tick(); pad = 8'h01;
        rises = 0; falls = 0; highs = 0;
        for (int c = 0; c < 8; c++) begin
            tick();
            if (rise_v[3]) rises++;
            if (fall_v[3]) falls++;
            if (in_v[3]) highs++;
        end
        check_eq("t4_rise_cnt", rises, 32'd1);
        check_eq("t4_fall_cnt", falls, 32'd1);
        check_eq("t4_high_cycles", highs, 32'd1);

        // Clear strobe colliding with a new fall event on pad 2.
        rise_en = 8'h04; fall_en = 8'h04; mask = 8'h00;
        pad = 8'h05;
        for (int c = 0; c < 5; c++) tick();
        pad = 8'h01; waited = 0;
        while (!(m_filt[2] == 1'b0 && m_prev[2] == 1'b1) && waited < 10) begin tick(); waited++; end
        check_eq("t5_timeout", {31'h0, waited >= 10}, 32'd0);
        clr = 8'h04; tick(); clr = 8'h00;
        check_eq("t5_status2", {31'h0, stat_v[2]}, 32'd1);
        check_eq("t5_irq_masked", {31'h0, irq_v}, 32'd0);
        mask = 8'h04; #1;
        check_eq("t5_irq_unmasked", {31'h0, irq_v}, 32'd1);
        clr = 8'h04; tick(); clr = 8'h00; tick();
        check_eq("t5_cleared", {31'h0, stat_v[2]}, 32'd0);

        // Randomized traffic.
        for (int c = 0; c < 1500; c++) begin
            for (int k = 0; k < N; k++)
                if ($urandom_range(5, 0) == 0) pad[k] = ~pad[k];
            if (c % 100 == 0) begin
                filt_en  = 8'($urandom);
                filt_len = 8'($urandom_range(6, 0));
                rise_en  = 8'($urandom);
                fall_en  = 8'($urandom);
            end
            mask = 8'($urandom);
            clr  = ($urandom_range(7, 0) == 0) ? 8'($urandom) : 8'h00;
            gclr = ($urandom_range(199, 0) == 0);
            tick();
        end
        clr = 8'h00; gclr = 1'b0;

        // Asynchronous reset in the middle of a filter count.
        filt_en = 8'h00; rise_en = 8'hFF; fall_en = 8'h00; mask = 8'hFF; pad = 8'h0F;
        rst = 1'b1; tick(); rst = 1'b0;
        for (int c = 0; c < 5; c++) tick();
        filt_en = 8'hFF; filt_len = 8'd8; pad = 8'h00;
        for (int c = 0; c < 4; c++) tick();
        #2 rst = 1'b1; model_reset();
        #1;
        check_eq("t6_in", {24'h0, in_v}, 32'h0);
        check_eq("t6_status", {24'h0, stat_v}, 32'h0);
        check_eq("t6_irq", {31'h0, irq_v}, 32'h0);
        check_eq("t6_glitch", {16'h0, gcnt_v}, 32'h0);
        @(negedge clk); rst = 1'b0;
        rises = 0; falls = 0;
        for (int c = 0; c < 12; c++) begin
            tick();
            if (rise_v != 8'h00) rises++;
            if (fall_v != 8'h00) falls++;
        end
        check_eq("t6_no_pulse", rises + falls, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
